// File: rtl/wl_win3x3.sv
// wl_win3x3: raster-order 3x3 window generator with two line buffers.
// Fixed two-cycle latency, no backpressure, windows only fully inside the frame.
module wl_win3x3 #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rst_p,
  input  logic            din_vld,
  input  logic [DW-1:0]   din,
  input  logic            din_sof,
  input  logic            din_eol,
  output logic            win_vld,
  output logic [9*DW-1:0] win,
  output logic            win_sof,
  output logic            win_eol,
  output logic            err_ovf
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [AW-1:0] c;
  logic [1:0]    r;
  logic          full;
  logic          pend;

  logic [DW-1:0] buf1 [IMG_W];
  logic [DW-1:0] buf2 [IMG_W];
  logic [DW-1:0] rd1, rd2, d0;
  logic          v0, e0, s0, l0;
  logic [DW-1:0] col [3][3];
  logic          e1, s1, l1;

  logic          acc, wr, emit;
  logic          full_eff, pend_eff;
  logic [AW-1:0] c_eff;
  logic [1:0]    r_eff;
  logic [9*DW-1:0] win_d;

  always_comb begin
    acc      = din_vld && !rst_p && (state == ACTIVE || din_sof);
    c_eff    = din_sof ? '0 : c;
    r_eff    = din_sof ? '0 : r;
    full_eff = din_sof ? 1'b0 : full;
    pend_eff = din_sof || pend;
    wr       = acc && !full_eff;
    emit     = wr && r_eff == 2'd2 && c_eff >= AW'(2);
  end

  // read-before-write: buffer 2 takes the row that buffer 1 is giving up
  always_ff @(posedge clk) begin
    if (wr) begin
      rd1         <= buf1[c_eff];
      rd2         <= buf2[c_eff];
      buf1[c_eff] <= din;
      buf2[c_eff] <= buf1[c_eff];
    end
  end

  always_comb begin
    win_d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_d[DW*(3*i+j) +: DW] = col[j][i];
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state   <= IDLE;
      c       <= '0;
      r       <= '0;
      full    <= 1'b0;
      pend    <= 1'b0;
      err_ovf <= 1'b0;
      d0      <= '0;
      v0      <= 1'b0;
      e0      <= 1'b0;
      s0      <= 1'b0;
      l0      <= 1'b0;
      e1      <= 1'b0;
      s1      <= 1'b0;
      l1      <= 1'b0;
      win_vld <= 1'b0;
      win     <= '0;
      win_sof <= 1'b0;
      win_eol <= 1'b0;
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++)
          col[j][i] <= '0;
    end else begin
      d0 <= din;
      v0 <= wr;
      e0 <= emit;
      s0 <= emit && pend_eff;
      l0 <= emit && din_eol;
      if (acc) begin
        state <= ACTIVE;
        c     <= c_eff;
        r     <= r_eff;
        full  <= full_eff;
        pend  <= pend_eff && !emit;
        if (full_eff)
          err_ovf <= 1'b1;
        else if (din_sof)
          err_ovf <= 1'b0;
        if (din_eol) begin
          c    <= '0;
          full <= 1'b0;
          r    <= (r_eff == 2'd2) ? 2'd2 : r_eff + 2'd1;
        end else if (!full_eff) begin
          if (c_eff == AW'(IMG_W - 1))
            full <= 1'b1;
          else
            c <= c_eff + 1'b1;
        end
      end
      if (v0) begin
        col[0]    <= col[1];
        col[1]    <= col[2];
        col[2][0] <= rd2;
        col[2][1] <= rd1;
        col[2][2] <= d0;
      end
      e1      <= e0;
      s1      <= s0;
      l1      <= l0;
      win_vld <= e1;
      win_sof <= s1;
      win_eol <= l1;
      if (e1)
        win <= win_d;
    end
  end

endmodule

// File: tb/tb_wl_win3x3.sv
// tb_wl_win3x3: directed frames against a frame-level window model.
// Two instances: full-size buffers and an 8-pixel variant for overflow.
module tb_wl_win3x3;
  localparam int DW = 8;

  typedef struct {
    int              t;
    logic [9*DW-1:0] w;
    bit              s;
    bit              e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_p = 1'b1;
  logic din_vld = 1'b0;
  logic din_sof = 1'b0;
  logic din_eol = 1'b0;
  logic [DW-1:0] din = '0;

  logic wv_a, ws_a, we_a, eo_a;
  logic wv_b, ws_b, we_b, eo_b;
  logic [9*DW-1:0] w_a, w_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  exp_t q[$];
  bit m_act, m_full, m_err, m_pend;
  int m_r, m_c;
  logic [DW-1:0] img [3][16];

  int nwin, first_cyc, last_cyc, sof_t, rise_cyc;
  logic [9*DW-1:0] first_w, last_w;
  bit last_e, prev_err;

  wl_win3x3 u_a (
    .clk(clk), .rst_p(rst_p), .din_vld(din_vld), .din(din),
    .din_sof(din_sof), .din_eol(din_eol), .win_vld(wv_a), .win(w_a),
    .win_sof(ws_a), .win_eol(we_a), .err_ovf(eo_a)
  );

  wl_win3x3 #(.DW(8), .IMG_W(8), .AW(3)) u_b (
    .clk(clk), .rst_p(rst_p), .din_vld(din_vld), .din(din),
    .din_sof(din_sof), .din_eol(din_eol), .win_vld(wv_b), .win(w_b),
    .win_sof(ws_b), .win_eol(we_b), .err_ovf(eo_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [71:0] act, logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0) && (q[0].t == cyc);
    chk("vld_a", wv_a, ev);
    chk("vld_b", wv_b, ev);
    if (ev) begin
      chk("win_a", w_a, q[0].w);
      chk("win_b", w_b, q[0].w);
      chk("sof_a", ws_a, q[0].s);
      chk("sof_b", ws_b, q[0].s);
      chk("eol_a", we_a, q[0].e);
      chk("eol_b", we_b, q[0].e);
      void'(q.pop_front());
    end
    chk("err_a", eo_a, 0);
    chk("err_b", eo_b, m_err);
    if (wv_a) begin
      nwin++;
      last_w = w_a;
      last_cyc = cyc;
      last_e = we_a;
      if (ws_a) begin
        first_w = w_a;
        first_cyc = cyc;
      end
    end
    if (eo_b && !prev_err) rise_cyc = cyc;
    prev_err = eo_b;
  end

  // model: full row index, image rows kept mod 3, window due 2 edges later
  task automatic px(bit v, logic [7:0] d, bit s, bit e, bit rst);
    @(negedge clk);
    #1;
    rst_p = rst;
    din_vld = v;
    din = d;
    din_sof = s;
    din_eol = e;
    if (rst) begin
      q.delete();
      m_act = 0; m_r = 0; m_c = 0;
      m_full = 0; m_err = 0; m_pend = 0;
    end else if (v && (m_act || s)) begin
      if (s) begin
        m_act = 1; m_r = 0; m_c = 0;
        m_full = 0; m_err = 0; m_pend = 1;
        sof_t = cyc + 1;
      end
      if (m_full) begin
        m_err = 1;
      end else begin
        img[m_r % 3][m_c] = d;
        if (m_r >= 2 && m_c >= 2) begin
          exp_t x;
          x.t = cyc + 3;
          x.w = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              x.w[DW*(3*i+j) +: DW] = img[(m_r-2+i) % 3][m_c-2+j];
          x.s = m_pend;
          x.e = e;
          q.push_back(x);
          m_pend = 0;
        end
      end
      if (e) begin
        m_r++;
        m_c = 0;
        m_full = 0;
      end else if (!m_full) begin
        if (m_c == 7) m_full = 1;
        else m_c++;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) px(0, 8'h00, 0, 0, 0);
  endtask

  task automatic pix_rc(int r, int c, int w, int base, int gap);
    logic [7:0] v;
    v = 8'(base + r*16 + c);
    px(1, v, r == 0 && c == 0, c == w-1, 0);
    idle(gap);
  endtask

  task automatic frame(int h, int w, int base, int gap);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pix_rc(r, c, w, base, gap);
  endtask

  task automatic clr();
    nwin = 0;
    first_cyc = -1;
    last_cyc = -1;
    rise_cyc = -1;
    first_w = '1;
    last_w = '1;
    last_e = 0;
  endtask

  initial begin
    clr();
    repeat (3) px(0, 8'h00, 0, 0, 1);
    idle(1);
    chk("rst_vld", wv_a, 0);
    chk("rst_win", w_a, 0);
    chk("rst_sof", ws_a, 0);
    chk("rst_eol", we_a, 0);
    chk("rst_err", eo_b, 0);

    clr();
    frame(4, 4, 0, 0);
    idle(4);
    chk("t1_n", nwin, 4);
    chk("t1_p00", first_w[7:0], 8'h00);
    chk("t1_p11", first_w[39:32], 8'h11);
    chk("t1_p22", first_w[71:64], 8'h22);
    chk("t1_cyc0", first_cyc, sof_t + 12);
    chk("t1_last", last_w[71:64], 8'h33);
    chk("t1_eol", last_e, 1);
    chk("t1_cyc3", last_cyc, sof_t + 17);

    clr();
    frame(4, 4, 0, 1);
    idle(4);
    chk("t2_n", nwin, 4);
    chk("t2_p11", first_w[39:32], 8'h11);
    chk("t2_cyc0", first_cyc, sof_t + 22);
    chk("t2_last", last_w[71:64], 8'h33);
    chk("t2_cyc3", last_cyc, sof_t + 32);

    clr();
    frame(5, 2, 0, 0);
    idle(4);
    chk("t3_n0", nwin, 0);
    chk("t3_err", eo_b, 0);
    clr();
    frame(3, 3, 0, 0);
    idle(4);
    chk("t3_n1", nwin, 1);
    chk("t3_ctr", first_w[39:32], 8'h11);
    chk("t3_cyc", first_cyc, sof_t + 10);

    clr();
    frame(1, 10, 0, 0);
    idle(2);
    chk("t4_err", eo_b, 1);
    chk("t4_rise", rise_cyc, sof_t + 8);
    clr();
    frame(4, 8, 0, 0);
    idle(4);
    chk("t4_clr", eo_b, 0);
    chk("t4_n", nwin, 12);
    chk("t4_p11", first_w[39:32], 8'h11);
    chk("t4_last", last_w[71:64], 8'h37);

    clr();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++)
        pix_rc(r, c, 6, 0, 0);
    pix_rc(3, 0, 6, 0, 0);
    frame(4, 4, 8'h80, 0);
    idle(4);
    chk("t5_n", nwin, 8);
    chk("t5_p00", first_w[7:0], 8'h80);
    chk("t5_p22", first_w[71:64], 8'hA2);
    chk("t5_cyc", first_cyc, sof_t + 12);
    chk("t5_last", last_w[71:64], 8'hB3);

    clr();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++)
        pix_rc(r, c, 6, 0, 0);
    for (int c = 0; c < 4; c++)
      pix_rc(3, c, 6, 0, 0);
    px(1, 8'h55, 0, 0, 1);
    idle(1);
    chk("t6_vld", wv_a, 0);
    chk("t6_win", w_a, 0);
    chk("t6_n", nwin, 4);
    repeat (4) px(1, 8'hEE, 0, 0, 0);
    px(1, 8'hEF, 0, 1, 0);
    idle(3);
    clr();
    frame(4, 4, 0, 0);
    idle(4);
    chk("t6_n2", nwin, 4);
    chk("t6_p22", first_w[71:64], 8'h22);
    chk("t6_cyc", first_cyc, sof_t + 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
